// File: rtl/carbon_boot_seq_monitor_pkg.sv
// Shared types for the Carbon boot-sequence monitor: verdict codes, FSM states
// and well-known tier codes.
package carbon_arch_pkg;

  typedef enum logic [3:0] {
    FC_NONE           = 4'd0,
    FC_RESET_TIER     = 4'd1,
    FC_STEP_TIMEOUT   = 4'd2,
    FC_CORE_MISMATCH  = 4'd3,
    FC_ILLEGAL_TIER   = 4'd4,
    FC_EARLY_POWEROFF = 4'd5,
    FC_PWROFF_TIMEOUT = 4'd6,
    FC_SIG_MISMATCH   = 4'd7
  } carbon_bootmon_fail_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHK_RST  = 3'd1,
    ST_STEP     = 3'd2,
    ST_WAIT_PWR = 3'd3,
    ST_PASS     = 3'd4,
    ST_FAIL     = 3'd5
  } carbon_bootmon_state_e;

  localparam logic [7:0] TIER_P0_I8080 = 8'h00;
  localparam logic [7:0] TIER_P7_Z480  = 8'h07;

  // A ladder shorter than two entries or longer than the hardware holds is
  // treated as a full-length ladder.
  function automatic int unsigned bm_clamp_steps(input int unsigned req,
                                                 input int unsigned max_steps);
    return ((req < 2) || (req > max_steps)) ? max_steps : req;
  endfunction

endpackage

// File: rtl/carbon_bootmon_timer.sv
// Saturating cycle counter with a programmable hit point; a zero limit never hits.
module carbon_bootmon_timer #(
  parameter int TO_W = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [TO_W-1:0] limit,
  output logic            hit
);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign hit = (limit != '0) && (r_cnt == limit);

endmodule

// File: rtl/carbon_boot_seq_monitor.sv
// Boot-sequence checker: follows the host tier/core through a programmed ladder,
// then waits for poweroff and checks the signature, latching a verdict.
module carbon_boot_seq_monitor
  import carbon_arch_pkg::*;
#(
  parameter int N_STEPS = 4,
  parameter int TIER_W  = 8,
  parameter int CORE_W  = 2,
  parameter int SIG_W   = 32,
  parameter int TO_W    = 20,
  parameter int STRICT  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [$clog2(N_STEPS):0]    cfg_n_steps,
  input  logic [N_STEPS*TIER_W-1:0]   cfg_exp_tier,
  input  logic [N_STEPS*CORE_W-1:0]   cfg_exp_core,
  input  logic [TO_W-1:0]             cfg_step_to,
  input  logic [TO_W-1:0]             cfg_pwr_to,
  input  logic [SIG_W-1:0]            cfg_exp_sig,
  input  logic [TIER_W-1:0]           mon_tier,
  input  logic [CORE_W-1:0]           mon_core,
  input  logic                        mon_poweroff,
  input  logic [SIG_W-1:0]            mon_signature,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [3:0]                  fail_code,
  output logic [$clog2(N_STEPS)-1:0]  fail_step,
  output logic [TIER_W-1:0]           got_tier,
  output logic [SIG_W-1:0]            got_sig,
  output logic [31:0]                 total_cycles
);

  localparam int STEP_W = $clog2(N_STEPS);

  carbon_bootmon_state_e r_state, w_state_next;
  carbon_bootmon_fail_e  r_fail_code, w_fail_next;

  logic [N_STEPS*TIER_W-1:0] r_cfg_tier;
  logic [N_STEPS*CORE_W-1:0] r_cfg_core;
  logic [TO_W-1:0]           r_cfg_step_to;
  logic [TO_W-1:0]           r_cfg_pwr_to;
  logic [SIG_W-1:0]          r_cfg_sig;
  logic [STEP_W-1:0]         r_last;
  logic [STEP_W-1:0]         r_step;
  logic [STEP_W-1:0]         r_fail_step;
  logic [TIER_W-1:0]         r_got_tier;
  logic [SIG_W-1:0]          r_got_sig;
  logic [31:0]               r_total;

  logic [TIER_W-1:0] w_exp_tier [N_STEPS];
  logic [CORE_W-1:0] w_exp_core [N_STEPS];
  logic [STEP_W-1:0] w_step_prev;
  logic [TO_W-1:0]   w_tmr_limit;
  logic              w_busy;
  logic              w_start_ok;
  logic              w_advance;
  logic              w_verdict;
  logic              w_tmr_clr;
  logic              w_hit;

  for (genvar gi = 0; gi < N_STEPS; gi++) begin : g_unpack
    assign w_exp_tier[gi] = r_cfg_tier[gi*TIER_W +: TIER_W];
    assign w_exp_core[gi] = r_cfg_core[gi*CORE_W +: CORE_W];
  end

  assign w_busy      = (r_state == ST_CHK_RST) || (r_state == ST_STEP) || (r_state == ST_WAIT_PWR);
  assign w_start_ok  = start && !w_busy;
  assign w_step_prev = r_step - 1'b1;

  // One timer serves both the per-step and the poweroff windows.
  assign w_tmr_limit = (r_state == ST_WAIT_PWR) ? r_cfg_pwr_to : r_cfg_step_to;
  assign w_tmr_clr   = !((r_state == ST_STEP) || (r_state == ST_WAIT_PWR)) || w_advance;

  carbon_bootmon_timer #(
    .TO_W (TO_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_tmr_clr),
    .en    (1'b1),
    .limit (w_tmr_limit),
    .hit   (w_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_fail_next  = FC_NONE;
    w_advance    = 1'b0;
    case (r_state)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) w_state_next = ST_CHK_RST;
      end
      ST_CHK_RST: begin
        if (mon_tier == w_exp_tier[0]) begin
          w_state_next = ST_STEP;
        end else begin
          w_state_next = ST_FAIL;
          w_fail_next  = FC_RESET_TIER;
        end
      end
      ST_STEP: begin
        // Priority: poweroff, tier match, illegal tier, timeout.
        if (mon_poweroff) begin
          w_state_next = ST_FAIL;
          w_fail_next  = FC_EARLY_POWEROFF;
        end else if (mon_tier == w_exp_tier[r_step]) begin
          if (mon_core == w_exp_core[r_step]) begin
            w_advance = 1'b1;
            if (r_step == r_last) w_state_next = ST_WAIT_PWR;
          end else begin
            w_state_next = ST_FAIL;
            w_fail_next  = FC_CORE_MISMATCH;
          end
        end else if ((STRICT != 0) && (mon_tier != w_exp_tier[w_step_prev])) begin
          w_state_next = ST_FAIL;
          w_fail_next  = FC_ILLEGAL_TIER;
        end else if (w_hit) begin
          w_state_next = ST_FAIL;
          w_fail_next  = FC_STEP_TIMEOUT;
        end
      end
      ST_WAIT_PWR: begin
        if (mon_poweroff) begin
          if (mon_signature == r_cfg_sig) begin
            w_state_next = ST_PASS;
          end else begin
            w_state_next = ST_FAIL;
            w_fail_next  = FC_SIG_MISMATCH;
          end
        end else if ((STRICT != 0) && (mon_tier != w_exp_tier[r_last])) begin
          w_state_next = ST_FAIL;
          w_fail_next  = FC_ILLEGAL_TIER;
        end else if (w_hit) begin
          w_state_next = ST_FAIL;
          w_fail_next  = FC_PWROFF_TIMEOUT;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_verdict = w_busy && ((w_state_next == ST_PASS) || (w_state_next == ST_FAIL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_tier    <= '0;
      r_cfg_core    <= '0;
      r_cfg_step_to <= '0;
      r_cfg_pwr_to  <= '0;
      r_cfg_sig     <= '0;
      r_last        <= '0;
      r_step        <= '0;
      r_fail_code   <= FC_NONE;
      r_fail_step   <= '0;
      r_got_tier    <= '0;
      r_got_sig     <= '0;
      r_total       <= '0;
    end else if (w_start_ok) begin
      r_cfg_tier    <= cfg_exp_tier;
      r_cfg_core    <= cfg_exp_core;
      r_cfg_step_to <= cfg_step_to;
      r_cfg_pwr_to  <= cfg_pwr_to;
      r_cfg_sig     <= cfg_exp_sig;
      r_last        <= STEP_W'(bm_clamp_steps(32'(cfg_n_steps), N_STEPS) - 1);
      r_step        <= '0;
      r_fail_code   <= FC_NONE;
      r_fail_step   <= '0;
      r_got_tier    <= '0;
      r_got_sig     <= '0;
      r_total       <= '0;
    end else begin
      if (w_busy && (r_total != 32'hFFFF_FFFF)) r_total <= r_total + 32'd1;
      if (r_state == ST_CHK_RST) begin
        r_step <= STEP_W'(1);
      end else if (w_advance && (r_step != r_last)) begin
        r_step <= r_step + 1'b1;
      end
      if (w_verdict) begin
        r_fail_code <= w_fail_next;
        r_fail_step <= r_step;
        r_got_tier  <= mon_tier;
        r_got_sig   <= mon_signature;
      end
    end
  end

  assign busy         = w_busy;
  assign done         = (r_state == ST_PASS) || (r_state == ST_FAIL);
  assign pass         = (r_state == ST_PASS);
  assign fail_code    = r_fail_code;
  assign fail_step    = r_fail_step;
  assign got_tier     = r_got_tier;
  assign got_sig      = r_got_sig;
  assign total_cycles = r_total;

endmodule
